// File: rtl/cordic_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : cordic_iter_core
// Description : Iterative rotation-mode CORDIC datapath and control FSM. One
//               micro-rotation per clock, indexed by an external counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_iter_core #(
    parameter int Width     = 16,
    parameter int Iters     = 16,
    parameter int IterWidth = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic signed [Width-1:0]     x_i,
    input  logic signed [Width-1:0]     y_i,
    input  logic signed [Width-1:0]     z_i,
    input  logic        [IterWidth-1:0] iter_i,
    input  logic                        last_i,
    output logic                        cnt_ena_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic signed [Width+1:0]     x_o,
    output logic signed [Width+1:0]     y_o,
    output logic signed [Width-1:0]     z_o
);

    localparam int                   c_LUT_DEPTH = 1 << IterWidth;
    localparam logic [IterWidth-1:0] c_RUN_LAST  = IterWidth'(Iters - 1);
    localparam logic [127:0]         c_ONE       = 128'd1 << 56;

    // atan(1/x) in Q56 via the alternating Taylor series, stopping once terms vanish.
    function automatic logic [127:0] f_atan_inv(input logic [127:0] x);
        logic [127:0] pw;
        logic [127:0] term;
        logic [127:0] acc;
        acc = '0;
        pw  = x;
        for (int k = 0; k < 48; k++) begin
            if (pw <= c_ONE) begin
                term = c_ONE / (pw * 128'(2 * k + 1));
                if (k % 2 == 0) acc = acc + term;
                else            acc = acc - term;
                pw = pw * x * x;
            end
        end
        return acc;
    endfunction

    // round(atan(2^-idx) * 2^(Width-1) / pi), pi taken from Machin's formula.
    function automatic logic [Width-1:0] f_atan(input int idx);
        logic [127:0] quarter_pi;
        logic [127:0] pi_q;
        logic [127:0] a;
        logic [127:0] num;
        quarter_pi = (128'd4 * f_atan_inv(128'd5)) - f_atan_inv(128'd239);
        pi_q       = quarter_pi << 2;
        a          = (idx == 0) ? quarter_pi : f_atan_inv(128'd1 << idx);
        num        = (a << Width) + pi_q;
        return Width'(num / (pi_q << 1));
    endfunction

    logic [Width-1:0] w_atan [c_LUT_DEPTH];

    for (genvar g = 0; g < c_LUT_DEPTH; g++) begin : g_atan
        if (g < Iters) begin : g_used
            localparam logic [Width-1:0] c_VAL = f_atan(g);
            assign w_atan[g] = c_VAL;
        end else begin : g_unused
            assign w_atan[g] = '0;
        end
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 err_q, err_d;
    logic [IterWidth-1:0] run_cnt_q, run_cnt_d;
    logic                 w_load;
    logic                 w_rotate;

    logic signed [Width+1:0] x_q, y_q;
    logic signed [Width-1:0] z_q;
    logic signed [Width+1:0] w_x_d, w_y_d;
    logic signed [Width-1:0] w_z_d;
    logic signed [Width+1:0] w_x_shr, w_y_shr;
    logic signed [Width-1:0] w_atan_sel;
    logic                    w_pos;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            err_q     <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        run_cnt_d = run_cnt_q;
        w_load    = 1'b0;
        w_rotate  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (last_i) err_d = 1'b1;
                if (start_i) begin
                    w_load    = 1'b1;
                    run_cnt_d = '0;
                    state_d   = S_RUN;
                    if (iter_i != '0) err_d = 1'b1;
                end
            end
            S_RUN: begin
                w_rotate  = 1'b1;
                run_cnt_d = run_cnt_q + IterWidth'(1);
                if (last_i) begin
                    state_d = S_DONE;
                end else if (run_cnt_q == c_RUN_LAST) begin
                    // Counter never flagged the last step: force completion.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (last_i) err_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // z == 0 rotates in the positive direction.
    assign w_pos      = ~z_q[Width-1];
    assign w_x_shr    = x_q >>> iter_i;
    assign w_y_shr    = y_q >>> iter_i;
    assign w_atan_sel = w_atan[iter_i];

    assign w_x_d = w_pos ? (x_q - w_y_shr)    : (x_q + w_y_shr);
    assign w_y_d = w_pos ? (y_q + w_x_shr)    : (y_q - w_x_shr);
    assign w_z_d = w_pos ? (z_q - w_atan_sel) : (z_q + w_atan_sel);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else if (w_load) begin
            x_q <= {{2{x_i[Width-1]}}, x_i};
            y_q <= {{2{y_i[Width-1]}}, y_i};
            z_q <= z_i;
        end else if (w_rotate) begin
            x_q <= w_x_d;
            y_q <= w_y_d;
            z_q <= w_z_d;
        end
    end

    assign cnt_ena_o = (state_q == S_RUN);
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign err_o     = err_q;
    assign x_o       = x_q;
    assign y_o       = y_q;
    assign z_o       = z_q;

endmodule
`default_nettype wire
